// File: rtl/reg_scoreboard_pkg.sv
// rtl/reg_scoreboard_pkg.sv - shared constants for the decode-stage register scoreboard
package reg_scoreboard_pkg;

  localparam int AW    = 6;
  localparam int NREGS = 2 ** AW;

  localparam logic [AW-1:0] REG_ZERO = 6'd0;
  localparam logic [AW-1:0] REG_LINK = 6'd31;

  localparam logic UNIT_INT = 1'b0;
  localparam logic UNIT_FPU = 1'b1;

  // Integer r0 is hardwired, so it never participates in hazard tracking.
  function automatic logic reg_tracked(input logic [AW-1:0] addr);
    return addr != REG_ZERO;
  endfunction

endpackage

// File: rtl/reg_scoreboard_popcount64.sv
// rtl/reg_scoreboard_popcount64.sv - combinational 64-bit population count
import reg_scoreboard_pkg::*;

module sb_popcount64 (
  input  logic [NREGS-1:0] bits,
  output logic [AW:0]      count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < NREGS; i++) begin
      count = count + {{AW{1'b0}}, bits[i]};
    end
  end

endmodule

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - pending/owner tracking and RAW/WAW decode stall
import reg_scoreboard_pkg::*;

module reg_scoreboard #(
  parameter int AW    = reg_scoreboard_pkg::AW,
  parameter int NREGS = reg_scoreboard_pkg::NREGS
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          issue_valid,
  input  logic [AW-1:0] issue_rs1,
  input  logic [AW-1:0] issue_rs2,
  input  logic          issue_rs1_used,
  input  logic          issue_rs2_used,
  input  logic [AW-1:0] issue_rd,
  input  logic          issue_rd_we,
  input  logic          issue_unit,
  output logic          issue_fire,
  output logic          stall,
  input  logic          wb0_valid,
  input  logic [AW-1:0] wb0_addr,
  input  logic          wb1_valid,
  input  logic [AW-1:0] wb1_addr,
  input  logic          flush,
  output logic [AW:0]   pending_count,
  output logic          err
);

  logic [NREGS-1:0] pend_q, owner_q;
  logic [NREGS-1:0] pend_d, owner_d;
  logic [AW:0]      count_d;
  logic             hazard;
  logic             err_d;

  // Hazards look only at registered state: a same-cycle writeback does not bypass.
  always_comb begin
    hazard = (issue_rs1_used && reg_tracked(issue_rs1) && pend_q[issue_rs1])
          || (issue_rs2_used && reg_tracked(issue_rs2) && pend_q[issue_rs2])
          || (issue_rd_we    && reg_tracked(issue_rd)  && pend_q[issue_rd]);
  end

  assign stall      = issue_valid & hazard;
  assign issue_fire = issue_valid & ~stall;

  // Writebacks clear before the issue sets, so a new destination is never lost.
  always_comb begin
    pend_d  = pend_q;
    owner_d = owner_q;
    if (flush) begin
      pend_d = pend_q & owner_q;
    end
    if (wb0_valid) pend_d[wb0_addr] = 1'b0;
    if (wb1_valid) pend_d[wb1_addr] = 1'b0;
    if (issue_fire && issue_rd_we && reg_tracked(issue_rd) && !flush) begin
      pend_d[issue_rd]  = 1'b1;
      owner_d[issue_rd] = issue_unit;
    end
  end

  always_comb begin
    err_d = (wb0_valid && reg_tracked(wb0_addr) && !pend_q[wb0_addr])
         || (wb1_valid && reg_tracked(wb1_addr) && !pend_q[wb1_addr])
         || (wb0_valid && wb1_valid && (wb0_addr == wb1_addr));
  end

  sb_popcount64 u_popcount (
    .bits  (pend_d),
    .count (count_d)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q        <= '0;
      owner_q       <= '0;
      pending_count <= '0;
      err           <= 1'b0;
    end else begin
      pend_q        <= pend_d;
      owner_q       <= owner_d;
      pending_count <= count_d;
      if (err_d) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb/tb_reg_scoreboard.sv - scoreboard-checked directed bench for reg_scoreboard
module tb_reg_scoreboard;

  localparam logic U_INT = 1'b0;
  localparam logic U_FPU = 1'b1;
  localparam int K_STALL = 0;
  localparam int K_FIRE  = 1;
  localparam int K_CNT   = 2;
  localparam int K_ERR   = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       issue_valid, issue_rs1_used, issue_rs2_used, issue_rd_we, issue_unit;
  logic [5:0] issue_rs1, issue_rs2, issue_rd;
  logic       issue_fire, stall;
  logic       wb0_valid, wb1_valid, flush;
  logic [5:0] wb0_addr, wb1_addr;
  logic [6:0] pending_count;
  logic       err;

  reg_scoreboard dut (
    .clk            (clk),
    .reset          (reset),
    .issue_valid    (issue_valid),
    .issue_rs1      (issue_rs1),
    .issue_rs2      (issue_rs2),
    .issue_rs1_used (issue_rs1_used),
    .issue_rs2_used (issue_rs2_used),
    .issue_rd       (issue_rd),
    .issue_rd_we    (issue_rd_we),
    .issue_unit     (issue_unit),
    .issue_fire     (issue_fire),
    .stall          (stall),
    .wb0_valid      (wb0_valid),
    .wb0_addr       (wb0_addr),
    .wb1_valid      (wb1_valid),
    .wb1_addr       (wb1_addr),
    .flush          (flush),
    .pending_count  (pending_count),
    .err            (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int    cyc;
    int    kind;
    int    val;
    string name;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passes = 0;

  // Monitor: expectations are tagged with the cycle they belong to and
  // compared against the DUT at the falling edge of that cycle.
  exp_t mon_e;
  int   mon_act;
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      mon_e = q.pop_front();
      case (mon_e.kind)
        K_STALL: mon_act = int'(stall);
        K_FIRE:  mon_act = int'(issue_fire);
        K_CNT:   mon_act = int'(pending_count);
        default: mon_act = int'(err);
      endcase
      checks++;
      if (mon_e.cyc != cyc || mon_act != mon_e.val)
        $display("FAIL %s (cycle %0d, checked in %0d): got %0d, expected %0d",
                 mon_e.name, mon_e.cyc, cyc, mon_act, mon_e.val);
      else
        passes++;
    end
  end

  task automatic chk(input int kind, input int val, input string name);
    exp_t e;
    e.cyc  = cyc;
    e.kind = kind;
    e.val  = val;
    e.name = name;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 0; issue_rs1 = 0; issue_rs2 = 0; issue_rs1_used = 0;
    issue_rs2_used = 0; issue_rd = 0; issue_rd_we = 0; issue_unit = U_INT;
    wb0_valid = 0; wb0_addr = 0; wb1_valid = 0; wb1_addr = 0; flush = 0;
  endtask

  task automatic iss(input logic [5:0] rs1, input logic u1, input logic [5:0] rs2,
                     input logic u2, input logic [5:0] rd, input logic we, input logic unit);
    idle();
    issue_valid = 1; issue_rs1 = rs1; issue_rs1_used = u1; issue_rs2 = rs2;
    issue_rs2_used = u2; issue_rd = rd; issue_rd_we = we; issue_unit = unit;
  endtask

  initial begin
    idle();
    step();
    iss(5, 1, 0, 0, 5, 1, U_INT);
    chk(K_STALL, 0, "reset_stall"); chk(K_FIRE, 1, "reset_fire");
    chk(K_CNT, 0, "reset_count");   chk(K_ERR, 0, "reset_err");
    step(); reset = 0; idle(); step();

    // RAW: producer rd=5, consumer stalls until wb0 lands, no bypass
    iss(0, 0, 0, 0, 5, 1, U_INT);
    chk(K_STALL, 0, "raw_prod_stall"); chk(K_FIRE, 1, "raw_prod_fire"); chk(K_CNT, 0, "raw_cnt0");
    step();
    iss(5, 1, 0, 0, 6, 1, U_INT);
    chk(K_STALL, 1, "raw_stall_c1"); chk(K_FIRE, 0, "raw_fire_c1"); chk(K_CNT, 1, "raw_cnt1");
    step();
    iss(5, 1, 0, 0, 6, 1, U_INT); chk(K_STALL, 1, "raw_stall_c2");
    step();
    iss(5, 1, 0, 0, 6, 1, U_INT); wb0_valid = 1; wb0_addr = 5;
    chk(K_STALL, 1, "raw_no_bypass"); chk(K_CNT, 1, "raw_cnt_wbcycle");
    step();
    iss(5, 1, 0, 0, 6, 1, U_INT);
    chk(K_STALL, 0, "raw_release"); chk(K_FIRE, 1, "raw_fire"); chk(K_CNT, 0, "raw_cnt_cleared");
    step();
    idle(); wb0_valid = 1; wb0_addr = 6; chk(K_CNT, 1, "raw_rd6_pending");
    step();
    idle(); chk(K_CNT, 0, "raw_done_cnt"); chk(K_ERR, 0, "raw_done_err");

    // WAW against FPU, then flush keeps an FPU-owned entry
    iss(0, 0, 0, 0, 33, 1, U_FPU); chk(K_FIRE, 1, "waw_fpu_fire");
    step();
    iss(0, 0, 0, 0, 33, 1, U_INT); chk(K_STALL, 1, "waw_stall"); chk(K_CNT, 1, "waw_cnt");
    step();
    iss(0, 0, 0, 0, 33, 1, U_INT); wb1_valid = 1; wb1_addr = 33; chk(K_STALL, 1, "waw_stall_wb");
    step();
    iss(0, 0, 0, 0, 33, 1, U_INT);
    chk(K_STALL, 0, "waw_release"); chk(K_FIRE, 1, "waw_fire"); chk(K_CNT, 0, "waw_cnt0");
    step();
    idle(); wb0_valid = 1; wb0_addr = 33; chk(K_CNT, 1, "waw_int_pending");
    step();
    iss(0, 0, 0, 0, 33, 1, U_FPU); chk(K_FIRE, 1, "fpu33_fire"); chk(K_CNT, 0, "fpu33_cnt0");
    step();
    idle(); flush = 1; chk(K_CNT, 1, "flush_cycle_cnt");
    step();
    iss(33, 1, 0, 0, 0, 0, U_INT); wb1_valid = 1; wb1_addr = 33;
    chk(K_STALL, 1, "flush_keeps_fpu"); chk(K_CNT, 1, "flush_keeps_cnt");
    step();
    idle(); chk(K_CNT, 0, "fpu33_done"); chk(K_ERR, 0, "fpu33_err");
    step();

    // Flush clears int-owned entries and suppresses a coincident issue
    iss(0, 0, 0, 0, 7, 1, U_INT); chk(K_FIRE, 1, "fl_int7_fire");
    step();
    iss(0, 0, 0, 0, 40, 1, U_FPU); chk(K_FIRE, 1, "fl_fpu40_fire"); chk(K_CNT, 1, "fl_cnt1");
    step();
    iss(0, 0, 0, 0, 9, 1, U_INT); flush = 1; chk(K_FIRE, 1, "fl_coinc_fire"); chk(K_CNT, 2, "fl_cnt2");
    step();
    iss(7, 1, 9, 1, 0, 0, U_INT);
    chk(K_STALL, 0, "fl_int_cleared"); chk(K_FIRE, 1, "fl_after_fire"); chk(K_CNT, 1, "fl_cnt_after");
    step();
    iss(40, 1, 0, 0, 0, 0, U_INT); wb1_valid = 1; wb1_addr = 40; chk(K_STALL, 1, "fl_fpu40_kept");
    step();
    idle(); chk(K_CNT, 0, "fl_done_cnt"); chk(K_ERR, 0, "fl_done_err");
    step();

    // r0 never tracked; wb0 to r0 is not an error
    for (int i = 0; i < 3; i++) begin
      iss(0, 1, 0, 1, 0, 1, U_INT);
      if (i == 1) begin wb0_valid = 1; wb0_addr = 0; end
      chk(K_STALL, 0, "r0_stall"); chk(K_CNT, 0, "r0_cnt");
      step();
    end
    idle(); chk(K_CNT, 0, "r0_cnt_end"); chk(K_ERR, 0, "r0_err");
    step();

    // err: writeback to non-pending register, sticky
    idle(); wb0_valid = 1; wb0_addr = 9; chk(K_ERR, 0, "err_before");
    step();
    idle(); chk(K_ERR, 1, "err_nonpending");
    step();
    idle(); chk(K_ERR, 1, "err_sticky");
    step();
    reset = 1; idle(); chk(K_ERR, 0, "err_reset_clears");
    step(); reset = 0; step();

    // err: both writeback ports to the same pending register
    iss(0, 0, 0, 0, 12, 1, U_INT); chk(K_FIRE, 1, "dual_fire");
    step();
    idle(); wb0_valid = 1; wb0_addr = 12; wb1_valid = 1; wb1_addr = 12;
    chk(K_CNT, 1, "dual_cnt1"); chk(K_ERR, 0, "dual_err_before");
    step();
    idle(); chk(K_ERR, 1, "dual_same_addr_err"); chk(K_CNT, 0, "dual_cnt0");
    step();
    reset = 1; chk(K_ERR, 0, "dual_reset");
    step(); reset = 0; step();

    // Fill 10 entries, then asynchronous reset in mid-cycle
    for (int i = 1; i <= 10; i++) begin
      iss(0, 0, 0, 0, 6'(i), 1, U_INT);
      chk(K_FIRE, 1, "fill_fire"); chk(K_CNT, i - 1, "fill_cnt");
      step();
    end
    iss(3, 1, 0, 0, 0, 0, U_INT); chk(K_STALL, 1, "fill_stall"); chk(K_CNT, 10, "fill_cnt10");
    step();
    iss(3, 1, 0, 0, 0, 0, U_INT);
    #2 reset = 1;
    chk(K_STALL, 0, "async_stall"); chk(K_FIRE, 1, "async_fire");
    chk(K_CNT, 0, "async_cnt"); chk(K_ERR, 0, "async_err");
    step(); reset = 0;
    idle(); wb1_valid = 1; wb1_addr = 40; chk(K_ERR, 0, "late_wb_err_before");
    step();
    idle(); chk(K_ERR, 1, "late_fpu_wb_err"); chk(K_CNT, 0, "late_cnt");
    step();

    for (int i = 0; i < 5 && q.size() > 0; i++) step();
    if (q.size() > 0) begin
      checks++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Register scoreboard for the pipelined processor's decode stage. Tracks outstanding writes to the 64-entry unified register file (32 integer + 32 FP, addressed as {FPSrc, Rs}) from the integer pipeline and the multi-cycle FPU. Generates the decode stall for RAW and WAW hazards and recovers pending state on a branch/jump flush. Sits between Control/decode and the issue register that feeds the ALU/FPU.

## Interface
Parameters:
- AW, 6, register address width ({fp_bit, 5-bit index})
- NREGS, 64, number of tracked registers (2**AW)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  reset, asynchronous, active-high
- issue_valid  in  1  decode holds a valid instruction
- issue_rs1, issue_rs2  in  [0:AW-1]  source addresses
- issue_rs1_used, issue_rs2_used  in  1  source is actually read
- issue_rd  in  [0:AW-1]  destination address (already muxed: Rs2/Rd/31)
- issue_rd_we  in  1  instruction writes issue_rd
- issue_unit  in  1  0 = integer pipe, 1 = FPU
- issue_fire  out  1  issue_valid & ~stall
- stall  out  1  hold decode/IAR this cycle
- wb0_valid, wb0_addr  in  1, [0:AW-1]  integer-pipe writeback
- wb1_valid, wb1_addr  in  1, [0:AW-1]  FPU writeback
- flush  in  1  squash younger integer-pipe instructions
- pending_count  out  [0:AW]  number of set pending bits (registered)
- err  out  1  sticky protocol-error flag

## Operation
- State per register: pending bit P[i], owner bit O[i] (unit of the in-flight write).
- Address 0 (integer r0) is never marked pending; hazards on it are ignored.
- Hazard = (rs1_used & P[rs1]) | (rs2_used & P[rs2]) | (rd_we & P[rd]), excluding address 0.
- stall = issue_valid & hazard. Combinational from registered P only; a writeback in the same cycle does NOT clear the hazard (no same-cycle bypass).
- On issue_fire & issue_rd_we & rd≠0 & ~flush: P[rd]←1, O[rd]←issue_unit.
- On wbN_valid: P[wbN_addr]←0. Both ports apply in the same cycle.
- flush: clears every P[i] with O[i]=0; FPU-owned entries retained. flush with issue_fire in the same cycle: the issue is not recorded. Writebacks in the flush cycle are still applied.
- err set (sticky until reset) on: wb to an address whose P=0 (excluding address 0); wb0 and wb1 valid to the same address in the same cycle.
- pending_count = popcount(P) after the update, registered.

## Timing
- Reset (async): all P, O = 0; pending_count = 0; err = 0; stall = 0 and issue_fire = issue_valid (outputs combinational).
- Set/clear visible on the cycle after the edge that records them: issue at edge N → stall possible from cycle N+1; wb at edge M → stall drops in cycle M+1.
- Minimum back-to-back dependent-issue gap: producer latency + 1 cycle.
- Reset asserted mid-operation discards all pending state; in-flight FPU writebacks arriving after reset raise err (expected; the pipeline must be flushed with reset).

## Structure
- Shared package: AW, NREGS, REG_ZERO = 6'd0, REG_LINK = 6'd31, unit encodings UNIT_INT = 1'b0, UNIT_FPU = 1'b1.
- One sub-module: sb_popcount64 (combinational 64-bit popcount feeding the pending_count register).
- Pending/owner arrays and err in the top block; no other hierarchy.

## Test plan
- Issue rd=5 int at cycle 0; dependent rs1=5 at cycle 1 → stall=1 until wb0 addr=5 at edge 3, stall=0 in cycle 4, pending_count 1→0.
- FPU rd=33 issued, then int rd=33 (WAW) → stall until wb1 addr=33; then flush → P[33] stays set while FPU owns it.
- Issue int rd=7 and FPU rd=40, then flush → P[7]=0, P[40]=1, pending_count=1; issue_fire coincident with flush → rd not recorded.
- Issue rd=0, rs1=0 repeatedly → never stall, pending_count stays 0.
- wb0 to non-pending addr 9 → err=1 and stays 1; wb0 and wb1 both to addr 12 same cycle → err=1.
- Fill 10 pending registers, assert reset asynchronously mid-cycle → P cleared, pending_count=0, stall=0 immediately.
